// File: rtl/jtcps_dtack_multi.sv
// 68000 DTACKn generator: programmable wait cycles, CH-way SDRAM busy arbitration, saturating delay debt.
// Optional JTCPS_DTACK_TIMEOUT_EN forces DTACKn after TOUT cen of waiting and raises a sticky tout_flag.
module jtcps_dtack_multi #(
  parameter int CH   = 2,
  parameter int WW   = 3,
  parameter int FW   = 4,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          ASn,
  input  logic [WW-1:0] wait_cnt,
  input  logic          hold,
  input  logic [CH-1:0] bus_cs,
  input  logic [CH-1:0] bus_busy,
  input  logic          rom_ok,
  output logic          DTACKn,
  output logic [FW-1:0] debt,
  output logic          tout_flag
);

  logic [WW-1:0] wcnt, wlat;
  logic          armed, charged, last_ASn;
  logic          fall, restart, base_done, sel_busy, is_bus;
  logic          norm_rel, early_rel, do_charge, tout_rel;

  if (TOUT < 1 || TOUT > 65535) begin : g_tout_range
    $error("jtcps_dtack_multi: TOUT must be within 1..65535");
  end

  always_comb begin
    fall      = !ASn && last_ASn;
    restart   = ASn || fall || hold;
    base_done = wcnt >= wlat;
    sel_busy  = |(bus_cs & bus_busy);
    is_bus    = |bus_cs;
    norm_rel  = base_done && (!is_bus || !sel_busy);
    // Repaying debt: release one CPU cycle before the base wait would end.
    // Gated on DTACKn so a stalled cen cannot repay twice in one access.
    early_rel = is_bus && !sel_busy && armed && (debt != '0) && (wlat != '0)
                && (wcnt == wlat - WW'(1)) && DTACKn;
    do_charge = is_bus && base_done && sel_busy && cen && armed && !charged && !(&debt);
  end

`ifdef JTCPS_DTACK_TIMEOUT_EN
  localparam logic [15:0] TOUT_C = 16'(TOUT);
  logic [15:0] tcnt;

  always_comb tout_rel = DTACKn && (tcnt >= TOUT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      tout_flag <= 1'b0;
    end else if (restart) begin
      tcnt <= '0;
    end else begin
      if (DTACKn && cen && !(&tcnt)) tcnt <= tcnt + 16'd1;
      if (tout_rel) tout_flag <= 1'b1;
    end
  end
`else
  always_comb tout_rel = 1'b0;
  assign tout_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DTACKn   <= 1'b1;
      debt     <= '0;
      wcnt     <= '0;
      wlat     <= '0;
      armed    <= 1'b0;
      charged  <= 1'b0;
      last_ASn <= 1'b1;
    end else begin
      last_ASn <= ASn;
      if (rom_ok) armed <= 1'b1;
      if (restart) begin
        DTACKn  <= 1'b1;
        wcnt    <= '0;
        charged <= 1'b0;
        // A hold restart keeps the latency latched at the strobe edge.
        if (fall) wlat <= wait_cnt;
      end else begin
        if (cen && !(&wcnt)) wcnt <= wcnt + WW'(1);
        if (norm_rel || early_rel || tout_rel) DTACKn <= 1'b0;
        if (early_rel) debt <= debt - FW'(1);
        if (do_charge) begin
          debt    <= debt + FW'(1);
          charged <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcps_dtack_multi.sv
// Directed bench for jtcps_dtack_multi: vector table of single accesses plus hand sequences.
module tb_jtcps_dtack_multi;

  logic       clk = 1'b0;
  logic       rst_n, cen, ASn, hold, rom_ok;
  logic [2:0] wait_cnt;
  logic [1:0] bus_cs, bus_busy;
  logic       DTACKn, tout_flag;
  logic [3:0] debt;

  int tests = 0;
  int fails = 0;

  jtcps_dtack_multi #(.CH(2), .WW(3), .FW(4), .TOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .ASn(ASn), .wait_cnt(wait_cnt),
    .hold(hold), .bus_cs(bus_cs), .bus_busy(bus_busy), .rom_ok(rom_ok),
    .DTACKn(DTACKn), .debt(debt), .tout_flag(tout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rom;
    logic [2:0] wc;
    logic [1:0] cs;
    logic [1:0] busy;
    int         bc;   // edges (from the strobe edge) during which busy is presented
    int         lat;  // expected edges until DTACKn is seen low
    int         dbt;  // expected debt after the access
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_access(input logic [2:0] wc, input logic [1:0] cs, input logic [1:0] busy,
                            input int bc, output int lat);
    wait_cnt = wc;
    bus_cs   = cs;
    bus_busy = (bc > 0) ? busy : 2'b00;
    ASn      = 1'b0;
    lat      = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n >= bc) bus_busy = 2'b00;
      if (DTACKn == 1'b0) begin
        lat = n;
        break;
      end
    end
    ASn      = 1'b1;
    bus_busy = 2'b00;
    bus_cs   = 2'b00;
    tick();
    check("dtack_high_after_rise", int'(DTACKn), 1);
    tick();
  endtask

  int lat;

  initial begin
    tbl[0]  = '{1'b0, 3'd2, 2'b01, 2'b00, 0, 4, 0};  // unarmed bus access, no busy
    tbl[1]  = '{1'b0, 3'd0, 2'b00, 2'b00, 0, 2, 0};  // non-bus, zero wait
    tbl[2]  = '{1'b0, 3'd1, 2'b01, 2'b01, 5, 6, 0};  // busy but unarmed: no charge
    tbl[3]  = '{1'b1, 3'd1, 2'b01, 2'b01, 5, 6, 1};  // armed busy: one charge
    tbl[4]  = '{1'b1, 3'd1, 2'b01, 2'b00, 0, 2, 0};  // early release repays
    tbl[5]  = '{1'b1, 3'd2, 2'b10, 2'b01, 5, 4, 0};  // busy on unselected channel
    tbl[6]  = '{1'b1, 3'd3, 2'b10, 2'b10, 3, 5, 0};  // busy clears before base wait
    tbl[7]  = '{1'b1, 3'd0, 2'b11, 2'b10, 4, 5, 1};  // both selected, one busy: charge
    tbl[8]  = '{1'b1, 3'd0, 2'b01, 2'b00, 0, 2, 1};  // wlat=0: no early release
    tbl[9]  = '{1'b1, 3'd2, 2'b00, 2'b00, 0, 4, 1};  // non-bus never repays
    tbl[10] = '{1'b1, 3'd3, 2'b01, 2'b00, 0, 4, 0};  // early release at wcnt==2

    rst_n = 1'b0; cen = 1'b1; ASn = 1'b1; hold = 1'b0; rom_ok = 1'b0;
    wait_cnt = 3'd0; bus_cs = 2'b00; bus_busy = 2'b00;
    tick(); tick();
    check("reset_dtack", int'(DTACKn), 1);
    check("reset_debt", int'(debt), 0);
    check("reset_tout", int'(tout_flag), 0);
    rst_n = 1'b1;
    tick(); tick();

    for (int i = 0; i < 11; i++) begin
      rom_ok = tbl[i].rom;
      run_access(tbl[i].wc, tbl[i].cs, tbl[i].busy, tbl[i].bc, lat);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_debt", i), int'(debt), tbl[i].dbt);
    end

    // Debt saturates at 15 over 20 busy accesses
    for (int k = 1; k <= 20; k++) begin
      run_access(3'd1, 2'b01, 2'b01, 5, lat);
      if (k == 1 || k >= 15) check($sformatf("sat%0d_debt", k), int'(debt), (k > 15) ? 15 : k);
    end
    check("sat_latency", lat, 6);
    run_access(3'd0, 2'b01, 2'b00, 0, lat);
    check("sat_wc0_latency", lat, 2);
    check("sat_wc0_debt", int'(debt), 15);
    run_access(3'd1, 2'b01, 2'b00, 0, lat);
    check("sat_early_latency", lat, 2);
    check("sat_early_debt", int'(debt), 14);

    // Hold mid-access restarts counting but keeps the latched wait
    wait_cnt = 3'd3; bus_cs = 2'b00; ASn = 1'b0;
    tick(); tick(); tick();
    check("hold_pre", int'(DTACKn), 1);
    hold = 1'b1; wait_cnt = 3'd0;
    tick(); tick();
    check("hold_active", int'(DTACKn), 1);
    hold = 1'b0;
    tick(); tick(); tick();
    check("hold_after_3", int'(DTACKn), 1);
    tick();
    check("hold_after_4", int'(DTACKn), 0);
    ASn = 1'b1; tick(); tick();

    // Wait counting advances only on cen
    cen = 1'b0; wait_cnt = 3'd1; ASn = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("cen_stalled", int'(DTACKn), 1);
    cen = 1'b1;
    tick();
    check("cen_one", int'(DTACKn), 1);
    tick();
    check("cen_release", int'(DTACKn), 0);

    // Asynchronous reset while DTACKn is low and debt is non-zero
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_dtack", int'(DTACKn), 1);
    check("arst_debt", int'(debt), 0);
    ASn = 1'b1; rom_ok = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // Busy stuck forever
    wait_cnt = 3'd0; bus_cs = 2'b01; bus_busy = 2'b01; ASn = 1'b0;
`ifdef JTCPS_DTACK_TIMEOUT_EN
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (DTACKn == 1'b0) begin
        lat = n;
        break;
      end
    end
    check("tout_latency", lat, 10);
    check("tout_flag_set", int'(tout_flag), 1);
    check("tout_debt", int'(debt), 0);
    ASn = 1'b1; bus_busy = 2'b00; tick(); tick();
    check("tout_flag_sticky", int'(tout_flag), 1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    check("tout_flag_cleared", int'(tout_flag), 0);
`else
    for (int n = 0; n < 40; n++) tick();
    check("stuck_dtack", int'(DTACKn), 1);
    check("stuck_tout_flag", int'(tout_flag), 0);
    bus_busy = 2'b00;
    tick(); tick();
    check("stuck_released", int'(DTACKn), 0);
    ASn = 1'b1; tick(); tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtcps_dtack_multi.md
Name: jtcps_dtack_multi

Overview:
- Parametrised successor to the CPS1 DTACK generator, for 68000-style bus cycles in CPS1/CPS1.5/CPS2 cores.
- Generates DTACKn after a programmable number of CPU wait cycles.
- Arbitrates readiness across CH SDRAM-backed bus channels.
- Tracks accumulated SDRAM delay in a saturating debt counter, repaid by shortening later bus accesses by one CPU cycle.

Parameters:
CH, 2, number of SDRAM bus channels (each with its own cs/busy pair).
WW, 3, width of the per-access wait-cycle count.
FW, 4, width of the delay debt counter.
TOUT, 255, CPU cycles before the optional timeout forces DTACKn (1..65535).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active low
cen  in  1  CPU clock enable; wait counting advances only here
ASn  in  1  CPU address strobe, active low
wait_cnt  in  WW  base wait cycles for this access; sampled at the ASn falling edge
hold  in  1  stall request (e.g. Z80 bus grant pending); forces a cycle restart
bus_cs  in  CH  per-channel chip select
bus_busy  in  CH  per-channel SDRAM busy
rom_ok  in  1  SDRAM initialised; arms delay compensation
DTACKn  out  1  data acknowledge, active low
debt  out  FW  current delay debt, in CPU cycles
tout_flag  out  1  sticky timeout indicator (optional feature)

Behaviour:
- Reset values: DTACKn=1, debt=0, tout_flag=0. Internal state: wcnt=0, armed=0, charged=0, last_ASn=1, wlat=0.
- armed: set when rom_ok=1; sticky until reset.
- Restart condition: ASn=1, OR an ASn falling edge (ASn=0 and last_ASn=1), OR hold=1. On restart:
  - DTACKn<=1, wcnt<=0, charged<=0.
  - wlat<=wait_cnt, sampled only on the falling edge.
  - hold=1 mid-cycle restarts counting but keeps wlat.
- While ASn=0 with no restart:
  - wcnt increments on each cen, saturating at all-ones.
  - base_done = (wcnt >= wlat).
  - sel_busy = |(bus_cs & bus_busy).
- Non-bus access (bus_cs==0): DTACKn<=0 when base_done. With wlat=0, DTACKn is low the clock after the falling edge.
- Bus access (bus_cs!=0):
  - Normal release: DTACKn<=0 when !sel_busy and base_done.
  - Early release: DTACKn<=0 when !sel_busy, armed, debt!=0, wlat!=0 and wcnt==wlat-1. Same clock: debt<=debt-1.
  - Charge: when base_done, sel_busy, cen, armed, !charged and debt!=max, then debt<=debt+1 and charged<=1. At most one charge per access.
  - debt saturates at 2^FW-1; never underflows.
  - Charge and early release cannot coincide: early release implies !base_done.
- Once DTACKn=0 it stays 0 until the next restart.
- bus_cs changing mid-access: readiness is re-evaluated on every clock with the current bus_cs.
- Asynchronous reset mid-cycle: DTACKn=1 immediately; debt cleared.

Optional Feature:
- Macro JTCPS_DTACK_TIMEOUT_EN.
- When defined:
  - A 16-bit counter counts cen while ASn=0 and DTACKn=1; it clears on restart.
  - When the count reaches TOUT, DTACKn<=0 regardless of sel_busy, and tout_flag<=1. tout_flag is sticky until reset.
  - debt is not modified by a timeout release.
- When undefined: no counter; tout_flag is tied to 0; DTACKn waits indefinitely on bus_busy.

Test Plan:
1. rom_ok=0, wait_cnt=2, bus_cs=1, bus_busy=0 -> DTACKn low on the clock after the 2nd cen following the ASn fall; debt stays 0.
2. Non-bus access, wait_cnt=0 -> DTACKn low one clk after ASn falls; high one clk after ASn rises.
3. armed, wait_cnt=1, bus_busy held 3 cen after base_done -> debt 0->1 exactly once. Next access with bus_busy=0 -> DTACKn asserts at wcnt==0 (one cycle early) and debt returns to 0.
4. 20 consecutive busy accesses with FW=4 -> debt saturates at 15 and does not wrap. With wait_cnt=0, no early release occurs and debt stays 15.
5. hold=1 during an access with wcnt=2 -> DTACKn stays 1 and wcnt restarts at 0 after hold drops. Multi-channel: bus_cs=2'b10, bus_busy=2'b01 -> not busy, so normal release.
6. JTCPS_DTACK_TIMEOUT_EN, TOUT=8, bus_busy stuck at 1 -> DTACKn low after 8 cen; tout_flag=1 until rst_n pulses low. Without the macro -> DTACKn stays 1 and tout_flag=0.
